// File: rtl/rf_issue_ctrl_pkg.sv
// Shared types for the rename-path issue controller: FSM encoding and ROB capacity derivation.
package rf_issue_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Tag 0 means "value ready" in the regfile, so one slot of the tag space is never allocated.
    function automatic int cap_of(input int add_w);
        return (1 << add_w) - 1;
    endfunction

endpackage

// File: rtl/rf_issue_ctrl_rob_tag_alloc.sv
// ROB tag allocator: tail pointer with zero-skipping wrap, in-flight count, full/empty flags.
module rob_tag_alloc
    import rf_issue_ctrl_pkg::*;
#(
    parameter int ROB_ADD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 alloc_i,
    input  logic                 rel_i,
    output logic [ROB_ADD_W-1:0] tail_o,
    output logic [ROB_ADD_W-1:0] cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [ROB_ADD_W-1:0] CAP       = ROB_ADD_W'(cap_of(ROB_ADD_W));
    localparam logic [ROB_ADD_W-1:0] TAG_FIRST = ROB_ADD_W'(1);

    logic [ROB_ADD_W-1:0] tail_q, tail_d;
    logic [ROB_ADD_W-1:0] cnt_q, cnt_d;
    logic                 rel_ok;

    // A release against an empty ROB has nothing to retire.
    assign rel_ok = rel_i && (cnt_q != '0);

    always_comb begin
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            tail_d = TAG_FIRST;
            cnt_d  = '0;
        end else begin
            if (alloc_i)
                tail_d = (tail_q == CAP) ? TAG_FIRST : tail_q + 1'b1;
            case ({alloc_i, rel_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_q <= TAG_FIRST;
            cnt_q  <= '0;
        end else begin
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tail_o  = tail_q;
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == CAP);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rf_issue_ctrl.sv
// Issue-side sequencer: handshake, ROB tag allocation, misprediction flush FSM.
// Optional counters oStallCyc/oFlushCnt are built when RF_ISSUE_STAT_EN is defined.
module rf_issue_ctrl
    import rf_issue_ctrl_pkg::*;
#(
    parameter int ROB_ADD_W = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 iIS_Valid,
    output logic                 oIS_Ready,
    input  logic                 iROB_Cmt,
    input  logic                 iROB_Mp,
    output logic                 oRF_En,
    output logic [ROB_ADD_W-1:0] oRF_Qn,
    output logic [ROB_ADD_W-1:0] oCnt,
    output logic                 oFull,
    output logic                 oEmpty
`ifdef RF_ISSUE_STAT_EN
    ,
    output logic [31:0]          oStallCyc,
    output logic [15:0]          oFlushCnt
`endif
);

    localparam int               FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYC - 1);

    state_e          state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            run, fire, rel, full;

    assign run       = (state_q == ST_RUN);
    // Ready depends on registered full only, so a commit never re-opens it in the same cycle.
    assign oIS_Ready = en && run && !iROB_Mp && !full;
    assign fire      = iIS_Valid && oIS_Ready;
    assign rel       = en && run && !iROB_Mp && iROB_Cmt;
    assign oRF_En    = fire;
    assign oFull     = full;

    rob_tag_alloc #(
        .ROB_ADD_W (ROB_ADD_W)
    ) u_tag (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (iROB_Mp),
        .alloc_i (fire),
        .rel_i   (rel),
        .tail_o  (oRF_Qn),
        .cnt_o   (oCnt),
        .full_o  (full),
        .empty_o (oEmpty)
    );

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (iROB_Mp) begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_LOAD;
        end else if (en && state_q == ST_FLUSH) begin
            if (fcnt_q == '0)
                state_d = ST_RUN;
            else
                fcnt_d = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef RF_ISSUE_STAT_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (en && iIS_Valid && !oIS_Ready && (stall_q != '1))
            stall_d = stall_q + 1'b1;
        if (iROB_Mp)
            flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign oStallCyc = stall_q;
    assign oFlushCnt = flush_q;
`endif

endmodule

// File: tb/tb_rf_issue_ctrl.sv
// Directed bench for rf_issue_ctrl; allocated tags are checked by a scoreboard monitor.
module tb_rf_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       iIS_Valid = 1'b0;
    logic       iROB_Cmt = 1'b0;
    logic       iROB_Mp = 1'b0;
    logic       oIS_Ready, oRF_En, oFull, oEmpty;
    logic [3:0] oRF_Qn, oCnt;
`ifdef RF_ISSUE_STAT_EN
    logic [31:0] oStallCyc;
    logic [15:0] oFlushCnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    rf_issue_ctrl #(.ROB_ADD_W(4), .FLUSH_CYC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .iIS_Valid (iIS_Valid),
        .oIS_Ready (oIS_Ready),
        .iROB_Cmt  (iROB_Cmt),
        .iROB_Mp   (iROB_Mp),
        .oRF_En    (oRF_En),
        .oRF_Qn    (oRF_Qn),
        .oCnt      (oCnt),
        .oFull     (oFull),
        .oEmpty    (oEmpty)
`ifdef RF_ISSUE_STAT_EN
        ,
        .oStallCyc (oStallCyc),
        .oFlushCnt (oFlushCnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected tag.
    always @(negedge clk) begin
        if (rst_n && oRF_En) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_tag: got unexpected fire tag %0d, want no fire", oRF_Qn);
            end else begin
                logic [3:0] want;
                want = exp_q.pop_front();
                if (oRF_Qn !== want) begin
                    failures++;
                    $display("FAIL sb_tag: got %0d want %0d", oRF_Qn, want);
                end
            end
        end
    end

    // One cycle: drive inputs after the edge, queue the expected tag, stop at the negedge.
    task automatic tick(input logic v, input logic c, input logic m, input logic e,
                        input logic exp_fire, input logic [3:0] exp_tag);
        @(posedge clk);
        #1;
        iIS_Valid = v;
        iROB_Cmt  = c;
        iROB_Mp   = m;
        en        = e;
        if (exp_fire) exp_q.push_back(exp_tag);
        @(negedge clk);
        chk("rf_en", {31'd0, oRF_En}, {31'd0, exp_fire});
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ready", {31'd0, oIS_Ready}, 32'd0);
        chk("rst_rfen",  {31'd0, oRF_En},    32'd0);
        chk("rst_qn",    {28'd0, oRF_Qn},    32'd1);
        chk("rst_cnt",   {28'd0, oCnt},      32'd0);
        chk("rst_full",  {31'd0, oFull},     32'd0);
        chk("rst_empty", {31'd0, oEmpty},    32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // fill: 15 fires with tags 1..15
        for (int i = 1; i <= 15; i++) tick(1, 0, 0, 1, 1, 4'(i));
        tick(1, 0, 0, 1, 0, 4'd0);
        chk("full_cnt",   {28'd0, oCnt},      32'd15);
        chk("full_flag",  {31'd0, oFull},     32'd1);
        chk("full_ready", {31'd0, oIS_Ready}, 32'd0);
        chk("full_empty", {31'd0, oEmpty},    32'd0);

        // commit at full: ready stays low this cycle, reopens next, tag wraps to 1
        tick(1, 1, 0, 1, 0, 4'd0);
        chk("cmt_ready_same", {31'd0, oIS_Ready}, 32'd0);
        tick(1, 0, 0, 1, 1, 4'd1);
        chk("cmt_cnt",        {28'd0, oCnt},      32'd14);
        chk("cmt_ready_next", {31'd0, oIS_Ready}, 32'd1);

        // drain 10 commits: 15 -> 5
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 1, 0, 4'd0);
        tick(0, 0, 0, 1, 0, 4'd0);
        chk("drain_cnt", {28'd0, oCnt}, 32'd5);

        // 20 cycles fire+commit: tags 2..15 then 1..6, cnt holds at 5
        for (int k = 0; k < 20; k++) tick(1, 1, 0, 1, 1, 4'(((1 + k) % 15) + 1));
        tick(0, 0, 0, 1, 0, 4'd0);
        chk("fc_cnt", {28'd0, oCnt},   32'd5);
        chk("fc_qn",  {28'd0, oRF_Qn}, 32'd7);

        // two more fires -> cnt 7, then mispredict with valid held
        tick(1, 0, 0, 1, 1, 4'd7);
        tick(1, 0, 0, 1, 1, 4'd8);
        tick(1, 0, 1, 1, 0, 4'd0);
        chk("mp_cnt_pre", {28'd0, oCnt},      32'd7);
        chk("mp_ready",   {31'd0, oIS_Ready}, 32'd0);
        tick(1, 1, 0, 1, 0, 4'd0);
        chk("fl1_ready", {31'd0, oIS_Ready}, 32'd0);
        chk("fl1_cnt",   {28'd0, oCnt},      32'd0);
        chk("fl1_qn",    {28'd0, oRF_Qn},    32'd1);
        tick(1, 1, 0, 1, 0, 4'd0);
        chk("fl2_ready", {31'd0, oIS_Ready}, 32'd0);
        chk("fl2_cnt",   {28'd0, oCnt},      32'd0);
        tick(1, 0, 0, 1, 1, 4'd1);
        chk("post_ready", {31'd0, oIS_Ready}, 32'd1);

        // repeated mispredict on first flush cycle extends the flush
        tick(0, 0, 1, 1, 0, 4'd0);
        tick(0, 1, 1, 1, 0, 4'd0);
        chk("rmp_ready", {31'd0, oIS_Ready}, 32'd0);
        tick(1, 1, 0, 1, 0, 4'd0);
        chk("rmp_fl1_ready", {31'd0, oIS_Ready}, 32'd0);
        tick(1, 1, 0, 1, 0, 4'd0);
        chk("rmp_fl2_ready", {31'd0, oIS_Ready}, 32'd0);
        chk("rmp_fl2_cnt",   {28'd0, oCnt},      32'd0);
        tick(1, 0, 0, 1, 1, 4'd1);

        // en low for 3 cycles with valid+commit: everything holds
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0, 0, 4'd0);
            chk("en0_ready", {31'd0, oIS_Ready}, 32'd0);
            chk("en0_cnt",   {28'd0, oCnt},      32'd1);
            chk("en0_qn",    {28'd0, oRF_Qn},    32'd2);
        end
        tick(0, 0, 0, 1, 0, 4'd0);
        chk("en1_cnt", {28'd0, oCnt},   32'd1);
        chk("en1_qn",  {28'd0, oRF_Qn}, 32'd2);
`ifdef RF_ISSUE_STAT_EN
        chk("stat_stall", oStallCyc,         32'd7);
        chk("stat_flush", {16'd0, oFlushCnt}, 32'd3);
`endif

        // asynchronous reset mid-run
        tick(1, 0, 0, 1, 1, 4'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("arst_ready", {31'd0, oIS_Ready}, 32'd0);
        chk("arst_rfen",  {31'd0, oRF_En},    32'd0);
        chk("arst_qn",    {28'd0, oRF_Qn},    32'd1);
        chk("arst_cnt",   {28'd0, oCnt},      32'd0);
        chk("arst_full",  {31'd0, oFull},     32'd0);
        chk("arst_empty", {31'd0, oEmpty},    32'd1);
`ifdef RF_ISSUE_STAT_EN
        chk("arst_stall", oStallCyc,          32'd0);
        chk("arst_flush", {16'd0, oFlushCnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 0, 0, 1, 1, 4'd1);
        tick(0, 0, 0, 1, 0, 4'd0);
        chk("final_cnt", {28'd0, oCnt}, 32'd1);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
